// File: rtl/reg_scan_pkg.sv
// Shared types and helpers for the register-file scan checker.
//   scan_state_e     : FSM state encoding (IDLE, WAIT, DONE)
//   err_count_width(): width of an error counter that can count every register
package reg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  function automatic int unsigned err_count_width(input int unsigned total_reg);
    return $clog2(total_reg + 1);
  endfunction

endpackage

// File: rtl/scan_latency_counter.sv
// Read-latency counter for the scan checker.
// Counts cycles since the register index last changed; hit marks the cycle
// in which the debug-port read data is valid.
// Ports:
//   CLK, RST  clock / synchronous active-high reset
//   clear     force count to 0 (has priority over enable)
//   enable    increment count
//   hit       count == ReadLatency-1
module scan_latency_counter #(
  parameter int unsigned ReadLatency = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int unsigned CntW = $clog2(ReadLatency + 1);
  localparam logic [CntW-1:0] HitVal = CntW'(ReadLatency - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == HitVal);

endmodule

// File: rtl/reg_scan_checker.sv
// Register-file dump sequencer: on start, walks the processor debug read port
// over registers 0..TotalReg-1, compares each value with an expected table and
// reports done/pass/mismatch count.
// Optional build macro FIRST_FAIL_CAPTURE_EN adds capture of the first
// mismatching register (fail_valid, fail_reg, fail_value, fail_exp).
// Ports:
//   CLK, RST   clock / synchronous active-high reset
//   start      begin scan (accepted in IDLE or DONE only)
//   inr        register index driven to the debug port
//   out_value  register value from the debug port
//   exp_addr   index into expected table (same as inr)
//   exp_data   expected value for exp_addr
//   busy       scan in progress
//   done       scan complete, held until start/RST
//   pass       done with zero mismatches
//   err_count  number of mismatching registers
module reg_scan_checker
  import reg_scan_pkg::*;
#(
  parameter int unsigned RegAddrBits = 3,
  parameter int unsigned DataWidth   = 16,
  parameter int unsigned TotalReg    = 8,
  parameter int unsigned ReadLatency = 1,
  localparam int unsigned ErrW       = err_count_width(TotalReg)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  output logic [RegAddrBits-1:0] inr,
  input  logic [DataWidth-1:0]   out_value,
  output logic [RegAddrBits-1:0] exp_addr,
  input  logic [DataWidth-1:0]   exp_data,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ErrW-1:0]        err_count
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic                   fail_valid,
  output logic [RegAddrBits-1:0] fail_reg,
  output logic [DataWidth-1:0]   fail_value,
  output logic [DataWidth-1:0]   fail_exp
`endif
);

  localparam logic [RegAddrBits-1:0] LastIdx = RegAddrBits'(TotalReg - 1);

  scan_state_e            state_q, state_d;
  logic [RegAddrBits-1:0] inr_q, inr_d;
  logic [ErrW-1:0]        err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic                   cnt_clear;
  logic                   cnt_en;
  logic                   lat_hit;
  logic                   mismatch;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic                   fail_valid_q, fail_valid_d;
  logic [RegAddrBits-1:0] fail_reg_q, fail_reg_d;
  logic [DataWidth-1:0]   fail_value_q, fail_value_d;
  logic [DataWidth-1:0]   fail_exp_q, fail_exp_d;
`endif

  scan_latency_counter #(
    .ReadLatency(ReadLatency)
  ) u_lat (
    .CLK   (CLK),
    .RST   (RST),
    .clear (cnt_clear),
    .enable(cnt_en),
    .hit   (lat_hit)
  );

  assign mismatch = (out_value != exp_data);

  always_comb begin
    state_d   = state_q;
    inr_d     = inr_q;
    err_d     = err_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
    fail_valid_d = fail_valid_q;
    fail_reg_d   = fail_reg_q;
    fail_value_d = fail_value_q;
    fail_exp_d   = fail_exp_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = WAIT;
          inr_d     = '0;
          err_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          cnt_clear = 1'b1;
`ifdef FIRST_FAIL_CAPTURE_EN
          fail_valid_d = 1'b0;
          fail_reg_d   = '0;
          fail_value_d = '0;
          fail_exp_d   = '0;
`endif
        end
      end
      WAIT: begin
        cnt_en = 1'b1;
        if (lat_hit) begin
          err_d = err_q + ErrW'(mismatch);
`ifdef FIRST_FAIL_CAPTURE_EN
          if (mismatch && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_reg_d   = inr_q;
            fail_value_d = out_value;
            fail_exp_d   = exp_data;
          end
`endif
          if (inr_q == LastIdx) begin
            // pass uses the count including this last sample
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            inr_d     = inr_q + RegAddrBits'(1);
            cnt_clear = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      inr_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inr_q   <= inr_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      fail_valid_q <= 1'b0;
      fail_reg_q   <= '0;
      fail_value_q <= '0;
      fail_exp_q   <= '0;
    end else begin
      fail_valid_q <= fail_valid_d;
      fail_reg_q   <= fail_reg_d;
      fail_value_q <= fail_value_d;
      fail_exp_q   <= fail_exp_d;
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_reg   = fail_reg_q;
  assign fail_value = fail_value_q;
  assign fail_exp   = fail_exp_q;
`endif

  assign inr       = inr_q;
  assign exp_addr  = inr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_reg_scan_checker.sv
module tb_reg_scan_checker;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned edge_n;
    logic [3:0]  err;
    logic        pss;
    logic [2:0]  last;
    logic        fv;
    logic [2:0]  freg;
    logic [15:0] fval;
    logic [15:0] fexp;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // dut0: default parameters (ReadLatency 1, 8 registers)
  logic        start0 = 1'b0;
  logic [2:0]  inr0, ea0;
  logic [15:0] out0, ed0;
  logic        busy0, done0, pass0;
  logic [3:0]  err0;
  logic [15:0] regs0[8];
  logic [15:0] tbl0[8];
  assign out0 = regs0[inr0];
  assign ed0  = tbl0[ea0];

  // dut1: ReadLatency 3, debug port modelled with 2 pipeline stages
  logic        start1 = 1'b0;
  logic [2:0]  inr1, ea1;
  logic [15:0] out1, ed1;
  logic        busy1, done1, pass1;
  logic [3:0]  err1;
  logic [15:0] regs1[8];
  logic [15:0] tbl1[8];
  logic [2:0]  d1a = 3'd0, d1b = 3'd0;
  always @(posedge CLK) begin
    d1a <= inr1;
    d1b <= d1a;
  end
  assign out1 = regs1[d1b];
  assign ed1  = tbl1[ea1];

  // dut2: single register, ReadLatency 2
  logic        start2 = 1'b0;
  logic [2:0]  inr2, ea2;
  logic [15:0] out2, ed2;
  logic        busy2, done2, pass2;
  logic [0:0]  err2;
  logic [15:0] reg2;
  logic [15:0] tbl2;
  assign out2 = reg2;
  assign ed2  = tbl2;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic fv0, fv1, fv2;
  logic [2:0] freg0, freg1, freg2;
  logic [15:0] fval0, fval1, fval2, fexp0, fexp1, fexp2;
`endif

  reg_scan_checker #(.RegAddrBits(3), .DataWidth(16), .TotalReg(8), .ReadLatency(1)) u_dut0 (
    .CLK(CLK), .RST(RST), .start(start0), .inr(inr0), .out_value(out0), .exp_addr(ea0),
    .exp_data(ed0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_valid(fv0), .fail_reg(freg0), .fail_value(fval0), .fail_exp(fexp0)
`endif
  );

  reg_scan_checker #(.RegAddrBits(3), .DataWidth(16), .TotalReg(8), .ReadLatency(3)) u_dut1 (
    .CLK(CLK), .RST(RST), .start(start1), .inr(inr1), .out_value(out1), .exp_addr(ea1),
    .exp_data(ed1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_valid(fv1), .fail_reg(freg1), .fail_value(fval1), .fail_exp(fexp1)
`endif
  );

  reg_scan_checker #(.RegAddrBits(3), .DataWidth(16), .TotalReg(1), .ReadLatency(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .start(start2), .inr(inr2), .out_value(out2), .exp_addr(ea2),
    .exp_data(ed2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_valid(fv2), .fail_reg(freg2), .fail_value(fval2), .fail_exp(fexp2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not as required", name);
  endtask

  task automatic check_result(input string tag, input exp_t e, input int unsigned at,
                              input logic [3:0] err, input logic pss, input logic [2:0] idx,
                              input logic bsy);
    check({tag, "_done_edge"}, at, e.edge_n);
    check({tag, "_err_count"}, {28'd0, err}, {28'd0, e.err});
    check({tag, "_pass"}, {31'd0, pss}, {31'd0, e.pss});
    check({tag, "_inr_last"}, {29'd0, idx}, {29'd0, e.last});
    check({tag, "_busy_at_done"}, {31'd0, bsy}, 32'd0);
  endtask

  // Monitors: pop the expected result whenever a DUT raises done
  logic dp0 = 1'b0, dp1 = 1'b0, dp2 = 1'b0;
  exp_t e0, e1, e2;

  always @(negedge CLK) begin
    if (done0 && !dp0) begin
      if (q0.size() == 0) fail_now("d0_unexpected_done");
      else begin
        e0 = q0.pop_front();
        check_result("d0", e0, cyc, err0, pass0, inr0, busy0);
`ifdef FIRST_FAIL_CAPTURE_EN
        check("d0_fail_valid", {31'd0, fv0}, {31'd0, e0.fv});
        check("d0_fail_reg", {29'd0, freg0}, {29'd0, e0.freg});
        check("d0_fail_value", {16'd0, fval0}, {16'd0, e0.fval});
        check("d0_fail_exp", {16'd0, fexp0}, {16'd0, e0.fexp});
`endif
      end
    end
    dp0 = done0;
  end

  always @(negedge CLK) begin
    if (done1 && !dp1) begin
      if (q1.size() == 0) fail_now("d1_unexpected_done");
      else begin
        e1 = q1.pop_front();
        check_result("d1", e1, cyc, err1, pass1, inr1, busy1);
`ifdef FIRST_FAIL_CAPTURE_EN
        check("d1_fail_valid", {31'd0, fv1}, {31'd0, e1.fv});
        check("d1_fail_reg", {29'd0, freg1}, {29'd0, e1.freg});
        check("d1_fail_value", {16'd0, fval1}, {16'd0, e1.fval});
        check("d1_fail_exp", {16'd0, fexp1}, {16'd0, e1.fexp});
`endif
      end
    end
    dp1 = done1;
  end

  always @(negedge CLK) begin
    if (done2 && !dp2) begin
      if (q2.size() == 0) fail_now("d2_unexpected_done");
      else begin
        e2 = q2.pop_front();
        check_result("d2", e2, cyc, {3'd0, err2}, pass2, inr2, busy2);
`ifdef FIRST_FAIL_CAPTURE_EN
        check("d2_fail_valid", {31'd0, fv2}, {31'd0, e2.fv});
        check("d2_fail_value", {16'd0, fval2}, {16'd0, e2.fval});
        check("d2_fail_exp", {16'd0, fexp2}, {16'd0, e2.fexp});
`endif
      end
    end
    dp2 = done2;
  end

  // Called at a negedge; the start edge E is the next posedge.
  task automatic pulse(input int which);
    case (which)
      0: start0 = 1'b1;
      1: start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    @(negedge CLK);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic go(input int which, input int unsigned scan_len, input logic [3:0] err,
                    input logic pss, input logic [2:0] last, input logic fv,
                    input logic [2:0] freg, input logic [15:0] fval, input logic [15:0] fexp);
    exp_t e;
    e.edge_n = cyc + 1 + scan_len;
    e.err = err; e.pss = pss; e.last = last;
    e.fv = fv; e.freg = freg; e.fval = fval; e.fexp = fexp;
    case (which)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    pulse(which);
  endtask

  task automatic wait_sb(input string tag);
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      fail_now({tag, "_done_timeout"});
      q0.delete();
      q1.delete();
      q2.delete();
    end
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    regs0 = '{16'h0000, 16'hFFFF, 16'h0009, 16'hFFFF, 16'h000A, 16'h0000, 16'h0000, 16'h0000};
    tbl0  = regs0;
    regs1 = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 16'h0077, 16'h0088};
    tbl1  = regs1;
    tbl1[2] = 16'h0FFF;
    tbl1[5] = 16'h0000;
    reg2 = 16'hABCD;
    tbl2 = 16'hABCD;

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_inr", {29'd0, inr0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_pass", {31'd0, pass0}, 32'd0);
    check("rst_err_count", {28'd0, err0}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // clean scan of the halted test program
    go(0, 8, 4'd0, 1'b1, 3'd7, 1'b0, 3'd0, 16'h0000, 16'h0000);
    wait_sb("t1");

    // entry 4 expected 000B, register holds 000A; start from DONE
    tbl0[4] = 16'h000B;
    go(0, 8, 4'd1, 1'b0, 3'd7, 1'b1, 3'd4, 16'h000A, 16'h000B);
    wait_sb("t2");

    // restart from DONE clears status; a start while busy is ignored
    tbl0[4] = 16'h000A;
    go(0, 8, 4'd0, 1'b1, 3'd7, 1'b0, 3'd0, 16'h0000, 16'h0000);
    check("t5_done_drops", {31'd0, done0}, 32'd0);
    check("t5_err_clears", {28'd0, err0}, 32'd0);
    check("t5_busy", {31'd0, busy0}, 32'd1);
    @(negedge CLK);
    pulse(0);
    wait_sb("t5");

    // full-width compare at first (bit 0) and last (bit 15) registers
    tbl0[0] = 16'h0001;
    tbl0[7] = 16'h8000;
    go(0, 8, 4'd2, 1'b0, 3'd7, 1'b1, 3'd0, 16'h0000, 16'h0001);
    wait_sb("edges");
    repeat (3) @(negedge CLK);
    check("done_hold", {31'd0, done0}, 32'd1);
    check("done_hold_inr", {29'd0, inr0}, 32'd7);
    check("done_hold_err", {28'd0, err0}, 32'd2);

    // reset at E+4 mid-scan aborts it
    tbl0[7] = 16'h0000;
    pulse(0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("t4_inr", {29'd0, inr0}, 32'd0);
    check("t4_busy", {31'd0, busy0}, 32'd0);
    check("t4_done", {31'd0, done0}, 32'd0);
    check("t4_err_count", {28'd0, err0}, 32'd0);
    check("t4_pass", {31'd0, pass0}, 32'd0);
    tbl0[0] = 16'h0000;
    go(0, 8, 4'd0, 1'b1, 3'd7, 1'b0, 3'd0, 16'h0000, 16'h0000);
    wait_sb("t4");

    // ReadLatency 3, mismatches at 2 and 5
    go(1, 24, 4'd2, 1'b0, 3'd7, 1'b1, 3'd2, 16'h0033, 16'h0FFF);
    wait_sb("t3");

    // single register
    go(2, 2, 4'd0, 1'b1, 3'd0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    wait_sb("t6_pass");
    tbl2 = 16'h2BCD;
    go(2, 2, 4'd1, 1'b0, 3'd0, 1'b1, 3'd0, 16'hABCD, 16'h2BCD);
    wait_sb("t6_fail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
